data_sram_slave: RTL and testbench

Responder end of the CPU data-memory port: accepts the enable, byte-write-enable, address and write-data requests issued by the execute stage and returns read data one cycle later. It holds the word-addressed data RAM plus a small memory-mapped I/O window (LED register, cycle counter, scratch word). It sits at SoC level beside the core and is the block the memory stage reads `data_sram_rdata` from.

---
 rtl/data_sram_slave.sv | 133 +++++++++++++
 tb/tb_data_sram_slave.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_slave
// Description : CPU data-memory responder with a word-addressed RAM and a
//               16-byte MMIO window (LED, cycle counter, scratch, reserved).
//               Define DSRAM_CYCLE_COUNTER_EN to build the cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_slave #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'hbfaf_f000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led_out
);

    localparam logic [1:0] c_OFF_LED  = 2'd0;
    localparam logic [1:0] c_OFF_CNT  = 2'd1;
    localparam logic [1:0] c_OFF_SCR  = 2'd2;

    // Byte-wise merge used for both stores and the write-first read value.
    function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    logic                  w_mmio_hit;
    logic                  w_mmio_wr;
    logic                  w_ram_wr;
    logic [1:0]            w_off;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic [31:0]           w_ram_merged;
    logic [31:0]           w_cnt_rd;
    logic                  w_unused_ok;

    logic [31:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] scratch_q, scratch_d;

    assign w_mmio_hit   = data_sram_en && (data_sram_addr[31:4] == MMIO_BASE[31:4]);
    assign w_mmio_wr    = w_mmio_hit && (data_sram_we != 4'b0000);
    assign w_ram_wr     = data_sram_en && !w_mmio_hit && (data_sram_we != 4'b0000);
    assign w_off        = data_sram_addr[3:2];
    assign w_ram_idx    = data_sram_addr[ADDR_WIDTH+1:2];
    assign w_ram_merged = f_merge(mem_q[w_ram_idx], data_sram_wdata, data_sram_we);
    assign w_unused_ok  = &{1'b0, data_sram_addr[1:0]};

    // RAM contents survive reset; a request presented while in reset is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (resetn && w_ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_we[b]) mem_q[w_ram_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
        end
    end

`ifdef DSRAM_CYCLE_COUNTER_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (w_mmio_wr && (w_off == c_OFF_CNT)) cnt_d = 32'h0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= 32'h0;
        else         cnt_q <= cnt_d;
    end

    assign w_cnt_rd = cnt_q;
`else
    assign w_cnt_rd = 32'h0;
`endif

    always_comb begin
        led_d     = led_q;
        scratch_d = scratch_q;
        if (w_mmio_hit && (w_off == c_OFF_LED)) begin
            if (data_sram_we[0]) led_d[7:0]  = data_sram_wdata[7:0];
            if (data_sram_we[1]) led_d[15:8] = data_sram_wdata[15:8];
        end
        if (w_mmio_hit && (w_off == c_OFF_SCR)) begin
            scratch_d = f_merge(scratch_q, data_sram_wdata, data_sram_we);
        end
    end

    // Write-first: a store returns the post-write word; the counter returns its pre-edge value.
    always_comb begin
        rdata_d = rdata_q;
        if (data_sram_en) begin
            if (w_mmio_hit) begin
                case (w_off)
                    c_OFF_LED: rdata_d = {16'h0, led_d};
                    c_OFF_CNT: rdata_d = w_cnt_rd;
                    c_OFF_SCR: rdata_d = scratch_d;
                    default:   rdata_d = 32'h0;
                endcase
            end else begin
                rdata_d = w_ram_merged;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= 32'h0;
            led_q     <= 16'h0;
            scratch_q <= 32'h0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            scratch_q <= scratch_d;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led_out         = led_q;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_slave
// Description : Directed plus randomized self-checking bench for data_sram_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_slave;

    localparam logic [31:0] c_MMIO = 32'hbfaf_f000;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;

    data_sram_slave #(.ADDR_WIDTH(12), .MMIO_BASE(c_MMIO)) u_dut (
        .clk            (clk),
        .resetn         (resetn),
        .data_sram_en   (en),
        .data_sram_we   (we),
        .data_sram_addr (addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(rdata),
        .led_out        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    int edge_n = 0;
    int clr_edge = 0;

    logic [31:0] m_mem [0:4095];
    logic [15:0] m_led;
    logic [31:0] m_scr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Reference: applies one request (sampled at edge edge_n+1) and returns next rdata.
    function automatic logic [31:0] model(input logic [3:0] w, input logic [31:0] a,
                                          input logic [31:0] d);
        logic [31:0] r;
        if (a[31:4] == c_MMIO[31:4]) begin
            case (a[3:2])
                2'd0: begin
                    if (w[0]) m_led[7:0]  = d[7:0];
                    if (w[1]) m_led[15:8] = d[15:8];
                    r = {16'h0, m_led};
                end
                2'd1: begin
`ifdef DSRAM_CYCLE_COUNTER_EN
                    r = 32'(edge_n - clr_edge);
                    if (w != 4'h0) clr_edge = edge_n + 1;
`else
                    r = 32'h0;
`endif
                end
                2'd2: begin
                    m_scr = merge(m_scr, d, w);
                    r = m_scr;
                end
                default: r = 32'h0;
            endcase
        end else begin
            m_mem[a[13:2]] = merge(m_mem[a[13:2]], d, w);
            r = m_mem[a[13:2]];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        edge_n++;
    endtask

    task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       input bit chk_rd, input string tag);
        logic [31:0] exp;
        @(negedge clk);
        en = 1'b1; we = w; addr = a; wdata = d;
        exp = model(w, a, d);
        tick();
        #1;
        en = 1'b0; we = 4'h0;
        if (chk_rd) check({tag, "_rdata"}, rdata, exp);
        check({tag, "_led"}, {16'h0, led}, {16'h0, m_led});
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [31:0] a;
        logic [3:0]  w;
        int          sel;

        resetn = 1'b0; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
        m_led = 16'h0; m_scr = 32'h0;
        idle(3);
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        clr_edge = edge_n;

        req(4'hf, 32'h1c00_0100, 32'hdead_beef, 1, "wr_full");
        req(4'h0, 32'h1c00_0100, 32'h0, 1, "rd_full");
        check("rd_full_const", rdata, 32'hdead_beef);
        req(4'b0010, 32'h1c00_0100, 32'h0000_5500, 1, "wr_byte1");
        check("wr_byte1_const", rdata, 32'hdead_55ef);
        req(4'h0, 32'h1c00_0100, 32'h0, 1, "rd_byte1");

        req(4'hf, c_MMIO, 32'h0000_a5a5, 1, "led_wr");
        check("led_wr_const", {16'h0, led}, 32'h0000_a5a5);
        req(4'h0, c_MMIO, 32'h0, 1, "led_rd");
        req(4'b0100, c_MMIO, 32'h00ff_0000, 1, "led_we2");
        check("led_we2_const", {16'h0, led}, 32'h0000_a5a5);

        req(4'hf, c_MMIO + 32'h4, 32'h0, 0, "cnt_clr");
        idle(9);
        req(4'h0, c_MMIO + 32'h4, 32'h0, 1, "cnt_rd");
`ifdef DSRAM_CYCLE_COUNTER_EN
        check("cnt_rd_const", rdata, 32'd9);
`else
        check("cnt_rd_const", rdata, 32'd0);
`endif

        req(4'hf, c_MMIO + 32'hc, 32'hffff_ffff, 1, "rsv_wr");
        req(4'h0, c_MMIO + 32'hc, 32'h0, 1, "rsv_rd");
        req(4'b0101, c_MMIO + 32'h8, 32'h1234_5678, 1, "scr_wr");
        req(4'h0, c_MMIO + 32'h8, 32'h0, 1, "scr_rd");

        req(4'h0, 32'h1c00_0100 ^ 32'h0000_4000, 32'h0, 1, "alias_rd");
        check("alias_const", rdata, 32'hdead_55ef);
        held = rdata;
        idle(3);
        #1;
        check("idle_hold", rdata, held);

        // Reset asserted with a store pending; the store must be dropped.
        @(negedge clk);
        en = 1'b1; we = 4'hf; addr = 32'h1c00_0100; wdata = 32'h1111_1111;
        #2 resetn = 1'b0;
        #1;
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_led", {16'h0, led}, 32'h0);
        idle(2);
        @(negedge clk);
        en = 1'b0; we = 4'h0;
        resetn = 1'b1;
        clr_edge = edge_n;
        m_led = 16'h0; m_scr = 32'h0;
        req(4'h0, 32'h1c00_0100, 32'h0, 1, "post_rst_ram");
        check("post_rst_const", rdata, 32'hdead_55ef);
        req(4'h0, c_MMIO + 32'h8, 32'h0, 1, "post_rst_scr");

        for (int i = 0; i < 8; i++)
            req(4'hf, 32'h1c00_0000 + 32'(4 * i), $urandom, 1, "init");

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            a = $urandom;
            if (sel < 7) begin
                a[31:28] = 4'h1;
                a[13:2]  = 12'($urandom_range(0, 7));
            end else begin
                a[31:4] = c_MMIO[31:4];
                a[3:2]  = (sel == 7) ? 2'd0 : ((sel == 8) ? 2'd2 : 2'd3);
            end
            w = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            req(w, a, $urandom, 1, "rand");
            if ($urandom_range(0, 4) == 0) begin
                held = rdata;
                idle($urandom_range(1, 3));
                #1;
                check("rand_hold", rdata, held);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
